// File: rtl/inst_encoder_pkg.sv
// Shared definitions for the RV32I instruction encoder.
// - imm_type encodings, identical to the ones used by the core's
//   immediate generator, so an encoded word decodes back to the same value.
// - RV32I major opcode constants, handy for benches and program builders.
// - Field bundle registered by the first pipeline stage.
package inst_encoder_pkg;

    typedef enum logic [2:0] {
        IMM_I = 3'b000,
        IMM_S = 3'b001,
        IMM_B = 3'b010,
        IMM_U = 3'b011,
        IMM_J = 3'b100,
        IMM_R = 3'b101
    } imm_type_e;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    typedef struct packed {
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [31:0] imm;
        logic [2:0]  imm_type;
    } inst_fields_t;

endpackage

// File: rtl/inst_pack.sv
// Combinational RV32I packer and immediate legality check.
// Ports:
//   opcode, rd, rs1, rs2, funct3, funct7 - decoded instruction fields
//   imm      - signed immediate (byte offset for B/J)
//   imm_type - format select (see imm_type_e)
//   inst     - packed word, all-zero when err is set
//   err      - immediate not representable, or illegal format
module inst_pack
    import inst_encoder_pkg::*;
(
    input  logic [6:0]  opcode,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [31:0] imm,
    input  logic [2:0]  imm_type,
    output logic [31:0] inst,
    output logic        err
);

    imm_type_e fmt;
    assign fmt = imm_type_e'(imm_type);

    // A value fits a signed field of width N when all bits from N-1 up are copies
    // of the sign bit.
    logic fits_12;
    logic fits_13;
    logic fits_21;
    assign fits_12 = (imm[31:11] == '0) || (imm[31:11] == '1);
    assign fits_13 = (imm[31:12] == '0) || (imm[31:12] == '1);
    assign fits_21 = (imm[31:20] == '0) || (imm[31:20] == '1);

    logic [31:0] raw;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no
        // path through the case leaves it unassigned (which would infer a latch).
        raw = '0;
        err = 1'b0;
        case (fmt)
            IMM_I: begin
                raw = {imm[11:0], rs1, funct3, rd, opcode};
                err = !fits_12;
            end
            IMM_S: begin
                raw = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
                err = !fits_12;
            end
            IMM_B: begin
                raw = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
                err = imm[0] || !fits_13;
            end
            IMM_U: begin
                raw = {imm[31:12], rd, opcode};
                err = (imm[11:0] != 12'd0);
            end
            IMM_J: begin
                raw = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
                err = imm[0] || !fits_21;
            end
            IMM_R: begin
                raw = {funct7, rs2, rs1, funct3, rd, opcode};
            end
            default: begin
                err = 1'b1;
            end
        endcase
    end

    // Error words are emitted as all-zero so IMEM never holds a half-encoded value.
    assign inst = err ? 32'h0000_0000 : raw;

endmodule

// File: rtl/inst_encoder.sv
// Streaming RV32I instruction encoder: two-stage pipeline in front of an
// IMEM write port. Stage 1 captures the fields, stage 2 captures the packed
// word, its error flag and its word address.
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   clear               - synchronous flush, restarts addressing at BASE_ADDR
//   in_valid/in_ready   - input handshake for the in_* fields
//   in_*                - decoded fields, immediate and immediate format
//   out_valid/out_ready - output handshake
//   out_inst, out_addr  - encoded word and its word address
//   out_err             - word is an encoding error (out_inst is zero)
//   err_count           - saturating count of error words handed downstream
module inst_encoder
    import inst_encoder_pkg::*;
#(
    parameter int ADDR_WIDTH = 14,
    parameter int BASE_ADDR  = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [6:0]            in_opcode,
    input  logic [4:0]            in_rd,
    input  logic [4:0]            in_rs1,
    input  logic [4:0]            in_rs2,
    input  logic [2:0]            in_funct3,
    input  logic [6:0]            in_funct7,
    input  logic [31:0]           in_imm,
    input  logic [2:0]            in_imm_type,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [31:0]           out_inst,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic                  out_err,
    output logic [15:0]           err_count
);

    localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);

    inst_fields_t          in_fields;
    inst_fields_t          s1_fields;
    logic                  s1_valid;
    logic                  s2_valid;
    logic [ADDR_WIDTH-1:0] addr_cnt;
    logic [31:0]           pack_inst;
    logic                  pack_err;
    logic                  s2_load;
    logic                  s1_load;

    assign in_fields = '{opcode: in_opcode, rd: in_rd, rs1: in_rs1, rs2: in_rs2,
                         funct3: in_funct3, funct7: in_funct7, imm: in_imm,
                         imm_type: in_imm_type};

    // Each stage refills when it is empty or its content moves on this cycle.
    assign s2_load   = !s2_valid || out_ready;
    assign s1_load   = !s1_valid || s2_load;
    assign in_ready  = !clear && s1_load;
    assign out_valid = s2_valid;

    inst_pack u_pack (
        .opcode   (s1_fields.opcode),
        .rd       (s1_fields.rd),
        .rs1      (s1_fields.rs1),
        .rs2      (s1_fields.rs2),
        .funct3   (s1_fields.funct3),
        .funct7   (s1_fields.funct7),
        .imm      (s1_fields.imm),
        .imm_type (s1_fields.imm_type),
        .inst     (pack_inst),
        .err      (pack_err)
    );

    // NOTE: all state below uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_fields <= '0;
            s2_valid  <= 1'b0;
            out_inst  <= '0;
            out_err   <= 1'b0;
            out_addr  <= BASE;
            addr_cnt  <= BASE;
            err_count <= '0;
        end else if (clear) begin
            // Flush wins over any handshake in the same cycle.
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            addr_cnt  <= BASE;
            err_count <= '0;
        end else begin
            if (out_valid && out_ready && out_err && (err_count != 16'hFFFF)) begin
                err_count <= err_count + 16'd1;
            end
            if (s2_load) begin
                s2_valid <= s1_valid;
                // Bubbles leave the output payload and address counter untouched.
                if (s1_valid) begin
                    out_inst <= pack_inst;
                    out_err  <= pack_err;
                    out_addr <= addr_cnt;
                    addr_cnt <= addr_cnt + 1'b1;
                end
            end
            if (s1_load) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_fields <= in_fields;
                end
            end
        end
    end

endmodule

// File: tb/tb_inst_encoder.sv
// Scoreboard bench for inst_encoder. The driver pushes the hand-computed
// expected word when an input is accepted; a negedge monitor pops and
// compares whenever the DUT hands a word downstream. Legal words are also
// decoded with an immediate-generator model and compared to the input imm.
module tb_inst_encoder;
    import inst_encoder_pkg::*;

    localparam int AW = 2;

    logic          clk;
    logic          rst_n;
    logic          clear;
    logic          in_valid;
    logic          in_ready;
    logic [6:0]    in_opcode;
    logic [4:0]    in_rd;
    logic [4:0]    in_rs1;
    logic [4:0]    in_rs2;
    logic [2:0]    in_funct3;
    logic [6:0]    in_funct7;
    logic [31:0]   in_imm;
    logic [2:0]    in_imm_type;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_inst;
    logic [AW-1:0] out_addr;
    logic          out_err;
    logic [15:0]   err_count;

    inst_encoder #(.ADDR_WIDTH(AW), .BASE_ADDR(0)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
        .in_imm_type(in_imm_type),
        .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
        .out_addr(out_addr), .out_err(out_err), .err_count(err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]   inst;
        logic [AW-1:0] addr;
        logic          err;
        logic [31:0]   imm;
        logic [2:0]    typ;
    } exp_t;

    exp_t          sb[$];
    int            n_checks = 0;
    int            n_pass = 0;
    int            n_accepted = 0;
    int            cyc = 0;
    int            last_accept_cyc = 0;
    logic [AW-1:0] exp_addr = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Reference immediate generator (the core's decode side).
    function automatic logic [31:0] imm_gen(input logic [31:0] i, input logic [2:0] typ);
        case (typ)
            3'b000:  return {{20{i[31]}}, i[31:20]};
            3'b001:  return {{20{i[31]}}, i[31:25], i[11:7]};
            3'b010:  return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            3'b011:  return {i[31:12], 12'b0};
            3'b100:  return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            default: return 32'h0;
        endcase
    endfunction

    // Monitor: a transfer happens on the next rising edge when these hold now.
    exp_t e_mon;
    always @(negedge clk) begin
        if (rst_n && !clear && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_word: got %h at addr %0d, expected no word", out_inst, out_addr);
            end else begin
                e_mon = sb.pop_front();
                check("out_inst", out_inst, e_mon.inst);
                check("out_addr", 32'(out_addr), 32'(e_mon.addr));
                check("out_err", 32'(out_err), 32'(e_mon.err));
                if (!e_mon.err && e_mon.typ != 3'b101)
                    check("roundtrip_imm", imm_gen(out_inst, e_mon.typ), e_mon.imm);
            end
        end
    end

    // Drive one input; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [31:0] imm, input logic [2:0] typ,
                        input logic [31:0] exp_inst, input logic exp_err);
        exp_t e;
        bit   done = 0;
        in_valid = 1'b1; in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
        in_funct3 = f3; in_funct7 = f7; in_imm = imm; in_imm_type = typ;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (in_ready) begin
                e.inst = exp_inst; e.addr = exp_addr; e.err = exp_err; e.imm = imm; e.typ = typ;
                sb.push_back(e);
                exp_addr++;
                n_accepted++;
                last_accept_cyc = cyc;
                done = 1;
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (!done) begin
            n_checks++;
            $display("FAIL send_timeout: got in_ready 0 for 50 cycles, expected acceptance");
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && sb.size() != 0; i++) @(posedge clk);
        if (sb.size() != 0) begin
            n_checks++;
            $display("FAIL drain_timeout: got %0d words pending, expected 0", sb.size());
        end
        @(posedge clk); #1;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        #1;
        check("in_ready_during_clear", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        clear = 1'b0;
        sb.delete();
        exp_addr = '0;
        check("out_valid_after_clear", 32'(out_valid), 32'd0);
        check("err_count_after_clear", 32'(err_count), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1);
    end

    int t0;

    initial begin
        rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_opcode = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_funct3 = '0;
        in_funct7 = '0; in_imm = '0; in_imm_type = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_inst", out_inst, 32'd0);
        check("rst_out_err", 32'(out_err), 32'd0);
        check("rst_out_addr", 32'(out_addr), 32'd0);
        check("rst_err_count", 32'(err_count), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // addi x1,x0,-1 and its 2-cycle latency
        send(OP_IMM, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'hFFFF_FFFF, IMM_I, 32'hFFF0_0093, 1'b0);
        check("latency_stage1", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        check("latency_stage2", 32'(out_valid), 32'd1);
        drain();

        // Back-to-back S/B/J/U with junk in unused fields
        do_clear();
        send(OP_STORE, 5'd31, 5'd3, 5'd2, 3'b010, 7'h7F, 32'd8, IMM_S, 32'h0021_A423, 1'b0);
        t0 = last_accept_cyc;
        send(OP_BRANCH, 5'd9, 5'd0, 5'd0, 3'b000, 7'h55, 32'hFFFF_FFFC, IMM_B, 32'hFE00_0EE3, 1'b0);
        send(OP_JAL, 5'd1, 5'd17, 5'd21, 3'b111, 7'h7F, 32'd2048, IMM_J, 32'h0010_00EF, 1'b0);
        send(OP_LUI, 5'd5, 5'd7, 5'd9, 3'b101, 7'h11, 32'h1234_5000, IMM_U, 32'h1234_52B7, 1'b0);
        check("throughput_cycles", 32'(last_accept_cyc - t0), 32'd3);
        drain();

        // Illegal immediates / format
        do_clear();
        send(OP_IMM, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd2048, IMM_I, 32'h0, 1'b1);
        send(OP_BRANCH, 5'd0, 5'd1, 5'd2, 3'b000, 7'd0, 32'd3, IMM_B, 32'h0, 1'b1);
        send(OP_LUI, 5'd5, 5'd0, 5'd0, 3'b000, 7'd0, 32'h100, IMM_U, 32'h0, 1'b1);
        send(OP_REG, 5'd3, 5'd1, 5'd2, 3'b000, 7'd0, 32'd0, 3'b111, 32'h0, 1'b1);
        drain();
        check("err_count_four", 32'(err_count), 32'd4);

        // Backpressure: 3 offered, only 2 fit while stalled
        do_clear();
        out_ready = 1'b0;
        n_accepted = 0;
        fork
            begin
                send(OP_IMM, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd1, IMM_I, 32'h0010_0093, 1'b0);
                send(OP_IMM, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd2, IMM_I, 32'h0020_0093, 1'b0);
                send(OP_IMM, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd3, IMM_I, 32'h0030_0093, 1'b0);
            end
            begin
                repeat (5) @(posedge clk);
                #1;
                check("stall_accepted", 32'(n_accepted), 32'd2);
                check("stall_in_ready", 32'(in_ready), 32'd0);
                check("stall_out_valid", 32'(out_valid), 32'd1);
                check("stall_out_inst", out_inst, 32'h0010_0093);
                out_ready = 1'b1;
            end
        join
        drain();

        // Address wrap with ADDR_WIDTH=2
        do_clear();
        for (int k = 1; k <= 5; k++)
            send(OP_IMM, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'(k), IMM_I, 32'h93 | (32'(k) << 20), 1'b0);
        drain();

        // Clear with a word in flight
        send(OP_REG, 5'd3, 5'd1, 5'd2, 3'b000, 7'h20, 32'd0, IMM_R, 32'h4020_81B3, 1'b0);
        do_clear();
        send(OP_REG, 5'd3, 5'd1, 5'd2, 3'b000, 7'd0, 32'd0, IMM_R, 32'h0020_81B3, 1'b0);
        drain();

        // Async reset mid-stall
        do_clear();
        send(OP_REG, 5'd3, 5'd1, 5'd2, 3'b000, 7'd0, 32'd0, 3'b110, 32'h0, 1'b1);
        drain();
        check("err_count_one", 32'(err_count), 32'd1);
        out_ready = 1'b0;
        send(OP_IMM, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd1, IMM_I, 32'h0010_0093, 1'b0);
        send(OP_IMM, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd2, IMM_I, 32'h0020_0093, 1'b0);
        @(posedge clk); #2;
        rst_n = 1'b0;
        sb.delete();
        exp_addr = '0;
        #1;
        check("async_out_valid", 32'(out_valid), 32'd0);
        check("async_out_inst", out_inst, 32'd0);
        check("async_out_addr", 32'(out_addr), 32'd0);
        check("async_err_count", 32'(err_count), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        send(OP_IMM, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd5, IMM_I, 32'h0050_0093, 1'b0);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
